// File: rtl/cnn_pe_param.sv
// cnn_pe_param: parameterised CNN processing element with a lane-masked
// weight buffer, windowed MAC accumulation and requantised output.
module cnn_pe_param #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int ACCW  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          in_state,
    input  logic [LANES*DW-1:0] in_act,
    input  logic [DW-1:0]       wrb_data,
    input  logic [AW-1:0]       wrb_addr,
    input  logic [LANES-1:0]    wrb,
    input  logic [AW-1:0]       rdb_addr,
    input  logic [4:0]          shift,
    input  logic                relu_en,
    output logic [2:0]          out_state,
    output logic [DW-1:0]       out_data,
    output logic                sat_flag
);
    localparam int PW = 2*DW + 1;
    localparam int SW = 2*DW + 1 + $clog2(LANES);

    localparam logic [2:0] ST_INV = 3'd0;
    localparam logic [2:0] ST_VAL = 3'd1;
    localparam logic [2:0] ST_FIN = 3'd2;

    localparam logic signed [ACCW:0] UMAX =
        (ACCW+1)'((64'd1 << DW) - 64'd1);
    localparam logic signed [ACCW:0] SMAX =
        (ACCW+1)'((64'd1 << (DW-1)) - 64'd1);
    localparam logic signed [ACCW:0] SMIN = -SMAX - (ACCW+1)'(1);

    logic [2:0]             st_norm;
    logic [2:0]             s1_state, s2_state, s3_state;
    logic [LANES*DW-1:0]    s1_act;
    logic [4:0]             s1_shift, s2_shift, s3_shift;
    logic                   s1_relu, s2_relu, s3_relu;
    logic signed [PW-1:0]   prod [LANES];
    logic signed [SW-1:0]   sum, s2_sum;
    logic signed [ACCW-1:0] acc, acc_next, s3_r;
    logic signed [ACCW:0]   rnd, rr, q;
    logic [DW-1:0]          q_data;
    logic                   q_sat;

    assign st_norm = (in_state == ST_VAL || in_state == ST_FIN) ?
                     in_state : ST_INV;

    // Per-lane buffer; the registered read sees pre-write contents.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DW-1:0]        wmem [DEPTH];
        logic [DW-1:0]        w;
        logic signed [PW-1:0] a_ext, w_ext;

        always_ff @(posedge clk) begin
            if (wrb[k]) wmem[wrb_addr] <= wrb_data;
            w <= wmem[rdb_addr];
        end

        assign a_ext   = {{(PW-DW){1'b0}}, s1_act[k*DW +: DW]};
        assign w_ext   = {{(PW-DW){w[DW-1]}}, w};
        assign prod[k] = a_ext * w_ext;
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) sum = sum + SW'(prod[k]);
    end

    assign acc_next = acc + ACCW'(s2_sum);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_state <= ST_INV;
            s2_state <= ST_INV;
        end else begin
            s1_state <= st_norm;
            s2_state <= s1_state;
        end
        s1_act   <= in_act;
        s1_shift <= shift;
        s1_relu  <= relu_en;
        s2_sum   <= sum;
        s2_shift <= s1_shift;
        s2_relu  <= s1_relu;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s3_state <= ST_INV;
            acc      <= '0;
            s3_r     <= '0;
        end else begin
            s3_state <= s2_state;
            if (s2_state == ST_VAL) begin
                acc <= acc_next;
            end else if (s2_state == ST_FIN) begin
                acc  <= '0;
                s3_r <= acc_next;
            end
        end
        s3_shift <= s2_shift;
        s3_relu  <= s2_relu;
    end

    // Round half up, then clamp to the unsigned or signed output range.
    always_comb begin
        rnd = '0;
        if (s3_shift != 5'd0) rnd = (ACCW+1)'(1) << (s3_shift - 5'd1);
        rr     = {s3_r[ACCW-1], s3_r} + rnd;
        q      = rr >>> s3_shift;
        q_data = q[DW-1:0];
        q_sat  = 1'b0;
        if (s3_relu) begin
            if (q[ACCW]) begin
                q_data = '0;
            end else if (q > UMAX) begin
                q_data = UMAX[DW-1:0];
                q_sat  = 1'b1;
            end
        end else begin
            if (q > SMAX) begin
                q_data = SMAX[DW-1:0];
                q_sat  = 1'b1;
            end else if (q < SMIN) begin
                q_data = SMIN[DW-1:0];
                q_sat  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_state <= ST_INV;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_state <= s3_state;
            if (s3_state == ST_FIN) begin
                out_data <= q_data;
                sat_flag <= sat_flag | q_sat;
            end
        end
    end
endmodule

// File: tb/tb_cnn_pe_param.sv
// tb_cnn_pe_param: directed stimulus with a queue-based scoreboard
// for cnn_pe_param (LANES=4, DW=8).
module tb_cnn_pe_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_state;
    logic [31:0] in_act;
    logic [7:0]  wrb_data;
    logic [3:0]  wrb_addr;
    logic [3:0]  wrb;
    logic [3:0]  rdb_addr;
    logic [4:0]  shift;
    logic        relu_en;
    logic [2:0]  out_state;
    logic [7:0]  out_data;
    logic        sat_flag;

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         at;
    } exp_t;

    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc_n  = 0;
    logic [7:0] last_d = 8'd0;

    cnn_pe_param dut (
        .clk(clk), .reset(reset), .in_state(in_state),
        .in_act(in_act), .wrb_data(wrb_data),
        .wrb_addr(wrb_addr), .wrb(wrb), .rdb_addr(rdb_addr),
        .shift(shift), .relu_en(relu_en),
        .out_state(out_state), .out_data(out_data),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    // Monitor: pop an expectation whenever the DUT emits a FIN result.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_d = 8'd0;
        end else begin
            checks++;
            if (out_state > 3'd2) begin
                errors++;
                $display("FAIL state_code got %0d want <=2", out_state);
            end
            if (out_state == 3'd2) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fin at cycle %0d data %0h",
                             cyc_n, out_data);
                end else begin
                    e = sb.pop_front();
                    checks += 3;
                    if (out_data !== e.d) begin
                        errors++;
                        $display("FAIL out_data got %0h want %0h",
                                 out_data, e.d);
                    end
                    if (sat_flag !== e.s) begin
                        errors++;
                        $display("FAIL sat_flag got %0b want %0b",
                                 sat_flag, e.s);
                    end
                    if (cyc_n != e.at) begin
                        errors++;
                        $display("FAIL latency got cycle %0d want %0d",
                                 cyc_n, e.at);
                    end
                    last_d = e.d;
                end
            end else begin
                checks++;
                if (out_data !== last_d) begin
                    errors++;
                    $display("FAIL hold got %0h want %0h",
                             out_data, last_d);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] st, input logic [31:0] act,
                         input logic [3:0] rd, input logic [4:0] sh,
                         input logic re);
        in_state = st;
        in_act   = act;
        rdb_addr = rd;
        shift    = sh;
        relu_en  = re;
        @(posedge clk);
        #1;
        wrb      = 4'h0;
        in_state = 3'd0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wrb      = 4'hF;
        wrb_addr = a;
        wrb_data = d;
        drive(3'd0, 32'h0, 4'd0, 5'd0, 1'b0);
    endtask

    task automatic fin(input logic [31:0] act, input logic [3:0] rd,
                       input logic [4:0] sh, input logic re,
                       input logic [7:0] ed, input logic es);
        exp_t e;
        e.d = ed;
        e.s = es;
        e.at = cyc_n + 4;
        sb.push_back(e);
        drive(3'd2, act, rd, sh, re);
    endtask

    function automatic logic [31:0] act_a(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b + 8'd48, b + 8'd32, b + 8'd16, b};
    endfunction

    // Nine-cycle window worth 5280; optional bubbles at i=3 and i=6.
    task automatic win(input logic re, input logic [4:0] sh,
                       input logic [7:0] ed, input logic es,
                       input logic bub);
        for (int i = 0; i < 9; i++) begin
            if (bub && (i == 3 || i == 6))
                drive((i == 3) ? 3'd0 : 3'd5, 32'hFFFF_FFFF,
                      4'(i), 5'd0, 1'b0);
            if (i < 8) drive(3'd1, act_a(i), 4'(i), 5'd0, 1'b0);
            else       fin(act_a(i), 4'(i), sh, re, ed, es);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_state = 3'd0;
        in_act   = '0;
        wrb_data = '0;
        wrb_addr = '0;
        wrb      = '0;
        rdb_addr = '0;
        shift    = '0;
        relu_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 8'(out_state), 8'd0);
        chk("rst_data", out_data, 8'd0);
        chk("rst_sat", 8'(sat_flag), 8'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) wr(4'(i), 8'(i + 1));

        win(1'b1, 5'd6, 8'd83, 1'b0, 1'b0);

        wr(4'd0, 8'hFF);
        fin({4{8'd10}}, 4'd0, 5'd0, 1'b0, 8'hD8, 1'b0);
        fin({4{8'd10}}, 4'd0, 5'd0, 1'b1, 8'h00, 1'b0);
        wr(4'd0, 8'd1);

        win(1'b0, 5'd0, 8'd127, 1'b1, 1'b0);
        win(1'b1, 5'd6, 8'd83, 1'b1, 1'b1);

        fin({4{8'd1}}, 4'd0, 5'd0, 1'b0, 8'd4, 1'b1);
        fin({4{8'd2}}, 4'd0, 5'd0, 1'b0, 8'd8, 1'b1);

        wr(4'd3, 8'd2);
        wrb      = 4'hF;
        wrb_addr = 4'd3;
        wrb_data = 8'd5;
        fin({4{8'd1}}, 4'd3, 5'd0, 1'b0, 8'd8, 1'b1);
        fin({4{8'd1}}, 4'd3, 5'd0, 1'b0, 8'd20, 1'b1);
        wr(4'd3, 8'd4);
        repeat (6) drive(3'd0, 32'h0, 4'd0, 5'd0, 1'b0);

        // Partial window plus an in-flight FIN, both lost to reset.
        for (int i = 0; i < 4; i++)
            drive(3'd1, act_a(i), 4'(i), 5'd0, 1'b0);
        drive(3'd2, act_a(4), 4'd4, 5'd0, 1'b0);
        reset = 1'b1;
        drive(3'd0, 32'h0, 4'd0, 5'd0, 1'b0);
        chk("midrst_state", 8'(out_state), 8'd0);
        chk("midrst_data", out_data, 8'd0);
        chk("midrst_sat", 8'(sat_flag), 8'd0);
        reset = 1'b0;

        win(1'b1, 5'd6, 8'd83, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            drive(3'd0, 32'h0, 4'd0, 5'd0, 1'b0);
        repeat (6) drive(3'd0, 32'h0, 4'd0, 5'd0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0",
                     sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
